// File: rtl/ascon_result_gate_if.sv
// Result-gate bus: upstream voted results and status in, gated result and health status out.
interface ascon_result_gate_if #(
    parameter int y     = 40,
    parameter int CNT_W = 4
);
    logic [y-1:0]     cipher_text;
    logic [127:0]     tag;
    logic [y-1:0]     dec_plain_text;
    logic [127:0]     dec_tag;
    logic             encryption_ready;
    logic             decryption_ready;
    logic             message_authentication;
    logic             out_ready;
    logic             out_valid;
    logic [y-1:0]     out_ct;
    logic [127:0]     out_tag;
    logic             out_fault;
    logic [CNT_W-1:0] fault_count;
    logic             locked;
    logic             busy;

    modport master (
        output cipher_text, tag, dec_plain_text, dec_tag,
               encryption_ready, decryption_ready, message_authentication, out_ready,
        input  out_valid, out_ct, out_tag, out_fault, fault_count, locked, busy
    );

    modport slave (
        input  cipher_text, tag, dec_plain_text, dec_tag,
               encryption_ready, decryption_ready, message_authentication, out_ready,
        output out_valid, out_ct, out_tag, out_fault, fault_count, locked, busy
    );
endinterface

// File: rtl/ascon_result_gate.sv
// Gates an encrypt/decrypt result pair on fault markers, auth and timeout; result valid 2 cycles after the
// decryption edge, held stable under out_ready backpressure; locks out permanently after FAULT_LIMIT faults.
module ascon_result_gate #(
    parameter int           y              = 40,
    parameter logic [127:0] FAULT_CONSTANT = 128'h8C784,
    parameter int           FAULT_LIMIT    = 3,
    parameter int           CNT_W          = 4,
    parameter int           TIMEOUT        = 1023
) (
    input  logic               clk,
    input  logic               rst,
    ascon_result_gate_if.slave bus
);
    localparam int           TW   = $clog2(TIMEOUT + 1);
    localparam logic [y-1:0] FC_Y = FAULT_CONSTANT[y-1:0];

    typedef enum logic [2:0] {IDLE, WAIT_DEC, CHECK, HOLD, LOCK} state_t;

    state_t           state, state_nxt;
    logic             enc_prev, dec_prev;
    logic [TW-1:0]    tmo_cnt;
    logic [y-1:0]     ct_q, pt_q;
    logic [127:0]     tag_q, dtag_q;
    logic             auth_q, tmo_q, fault_q;
    logic [CNT_W-1:0] fault_count_q;
    logic             enc_edge, dec_edge;
    logic             cap_enc, cap_dec, tmo_hit, hs, fault_c;

    assign enc_edge = bus.encryption_ready & ~enc_prev;
    assign dec_edge = bus.decryption_ready & ~dec_prev;

    assign fault_c = (ct_q == FC_Y) | (tag_q == FAULT_CONSTANT) | (pt_q == FC_Y)
                   | (dtag_q == FAULT_CONSTANT) | ~auth_q | tmo_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_enc   = 1'b0;
        cap_dec   = 1'b0;
        tmo_hit   = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                if (enc_edge) begin
                    cap_enc   = 1'b1;
                    cap_dec   = dec_edge;
                    state_nxt = dec_edge ? CHECK : WAIT_DEC;
                end
            end
            WAIT_DEC: begin
                if (dec_edge) begin
                    cap_dec   = 1'b1;
                    state_nxt = CHECK;
                end else if (tmo_cnt == TW'(TIMEOUT)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = HOLD;
            HOLD: begin
                if (bus.out_ready) begin
                    hs        = 1'b1;
                    state_nxt = (fault_count_q >= CNT_W'(FAULT_LIMIT)) ? LOCK : IDLE;
                end
            end
            LOCK:    state_nxt = LOCK;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge history tracks the inputs in every state, so edges seen in CHECK/HOLD/LOCK are consumed, not deferred.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enc_prev      <= 1'b1;
            dec_prev      <= 1'b1;
            tmo_cnt       <= '0;
            ct_q          <= '0;
            tag_q         <= '0;
            pt_q          <= '0;
            dtag_q        <= '0;
            auth_q        <= 1'b0;
            tmo_q         <= 1'b0;
            fault_q       <= 1'b0;
            fault_count_q <= '0;
        end else begin
            enc_prev <= bus.encryption_ready;
            dec_prev <= bus.decryption_ready;
            tmo_cnt  <= (state == WAIT_DEC) ? tmo_cnt + 1'b1 : '0;
            if (cap_enc) begin
                ct_q  <= bus.cipher_text;
                tag_q <= bus.tag;
            end
            if (cap_dec) begin
                pt_q   <= bus.dec_plain_text;
                dtag_q <= bus.dec_tag;
                auth_q <= bus.message_authentication;
            end
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end
            if (state == CHECK) begin
                fault_q <= fault_c;
                if (fault_c && fault_count_q != '1) begin
                    fault_count_q <= fault_count_q + 1'b1;
                end
            end
            if (hs) begin
                ct_q    <= '0;
                tag_q   <= '0;
                pt_q    <= '0;
                dtag_q  <= '0;
                auth_q  <= 1'b0;
                tmo_q   <= 1'b0;
                fault_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = (state == HOLD);
    assign bus.out_fault   = fault_q;
    assign bus.out_ct      = (state == HOLD && !fault_q) ? ct_q : '0;
    assign bus.out_tag     = (state == HOLD && !fault_q) ? tag_q : '0;
    assign bus.fault_count = fault_count_q;
    assign bus.locked      = (state == LOCK);
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_ascon_result_gate.sv
// Directed bench for ascon_result_gate: transaction-level model checked every cycle plus literal spot checks.
module tb_ascon_result_gate;
    localparam int           TIMEOUT = 1023;
    localparam int           LIMIT   = 3;
    localparam logic [127:0] FC      = 128'h8C784;
    localparam logic [39:0]  FC40    = 40'h000008C784;

    typedef struct packed {
        logic [39:0]  ct;
        logic [127:0] tag;
        logic [39:0]  pt;
        logic [127:0] dtag;
        logic         auth;
        logic         tmo;
    } txn_t;

    logic clk;
    logic rst;
    ascon_result_gate_if #(.y(40), .CNT_W(4)) bus ();

    ascon_result_gate #(
        .y(40), .FAULT_CONSTANT(FC), .FAULT_LIMIT(LIMIT), .CNT_W(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_vld_cyc = 0;
    int n_hs   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level reference: what has been captured, and when each phase of the result is due.
    txn_t        cur;
    bit          m_wait, m_eval, m_show, m_lock;
    bit          m_enc_p = 1'b1, m_dec_p = 1'b1;
    bit          ee, de;
    int unsigned ecnt = 0, enc_at = 0;
    int          m_count = 0;

    function automatic bit faulty(input txn_t t);
        return (t.ct == FC40) || (t.tag == FC) || (t.pt == FC40) || (t.dtag == FC) || !t.auth || t.tmo;
    endfunction

    always @(posedge clk) begin
        ecnt++;
        ee = bus.encryption_ready && !m_enc_p;
        de = bus.decryption_ready && !m_dec_p;
        m_enc_p = bus.encryption_ready;
        m_dec_p = bus.decryption_ready;
        if (!rst) begin
            cur = '0; m_wait = 0; m_eval = 0; m_show = 0; m_lock = 0;
            m_count = 0; m_enc_p = 1'b1; m_dec_p = 1'b1;
        end else if (m_lock) begin
            m_lock = 1'b1;
        end else if (m_show) begin
            if (bus.out_ready) begin
                m_show = 0;
                cur = '0;
                if (m_count >= LIMIT) m_lock = 1;
            end
        end else if (m_eval) begin
            m_eval = 0;
            m_show = 1;
            if (faulty(cur) && m_count < 15) m_count++;
        end else if (m_wait) begin
            if (de) begin
                cur.pt = bus.dec_plain_text; cur.dtag = bus.dec_tag; cur.auth = bus.message_authentication;
                m_wait = 0; m_eval = 1;
            end else if (ecnt - enc_at == TIMEOUT + 1) begin
                cur.tmo = 1'b1;
                m_wait = 0; m_eval = 1;
            end
        end else if (ee) begin
            cur = '0;
            cur.ct = bus.cipher_text; cur.tag = bus.tag;
            enc_at = ecnt;
            if (de) begin
                cur.pt = bus.dec_plain_text; cur.dtag = bus.dec_tag; cur.auth = bus.message_authentication;
                m_eval = 1;
            end else begin
                m_wait = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) n_vld_cyc++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) n_hs++;
        if (cmp_en) begin
            chk("cyc_out_valid", bus.out_valid, m_show);
            chk("cyc_busy", bus.busy, m_wait || m_eval || m_show || m_lock);
            chk("cyc_locked", bus.locked, m_lock);
            chk("cyc_fault_count", bus.fault_count, m_count);
            if (m_show) begin
                chk("cyc_out_fault", bus.out_fault, faulty(cur));
                chk("cyc_out_ct", bus.out_ct, faulty(cur) ? 40'h0 : cur.ct);
                chk("cyc_out_tag", bus.out_tag, faulty(cur) ? 128'h0 : cur.tag);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enc_pulse(input logic [39:0] ct, input logic [127:0] t);
        bus.cipher_text = ct;
        bus.tag = t;
        bus.encryption_ready = 1'b1;
        tick();
        bus.encryption_ready = 1'b0;
    endtask

    task automatic dec_pulse(input logic [39:0] pt, input logic [127:0] t, input logic auth);
        bus.dec_plain_text = pt;
        bus.dec_tag = t;
        bus.message_authentication = auth;
        bus.decryption_ready = 1'b1;
        tick();
        bus.decryption_ready = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < max) begin
            tick();
            lat++;
        end
        chk("wait_out_valid", bus.out_valid, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag_name);
        chk({tag_name, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag_name, "_out_ct"}, bus.out_ct, 40'h0);
        chk({tag_name, "_out_tag"}, bus.out_tag, 128'h0);
        chk({tag_name, "_out_fault"}, bus.out_fault, 1'b0);
        chk({tag_name, "_fault_count"}, bus.fault_count, 4'd0);
        chk({tag_name, "_locked"}, bus.locked, 1'b0);
        chk({tag_name, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic clean_txn(input logic [39:0] ct, input logic [127:0] t, input string name);
        int l;
        enc_pulse(ct, t);
        tick(2);
        dec_pulse(40'h55, 128'h66, 1'b1);
        wait_valid(10, l);
        chk({name, "_latency"}, l + 1, 2);
        chk({name, "_out_ct"}, bus.out_ct, ct);
        chk({name, "_out_fault"}, bus.out_fault, 1'b0);
        tick();
        chk({name, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        int l, h0, v0;
        rst = 1'b0;
        bus.cipher_text = '0; bus.tag = '0; bus.dec_plain_text = '0; bus.dec_tag = '0;
        bus.encryption_ready = 1'b0; bus.decryption_ready = 1'b0;
        bus.message_authentication = 1'b0; bus.out_ready = 1'b1;
        tick(2);
        cmp_en = 1'b1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(2);

        // Clean transaction: two-cycle latency, data passes through.
        clean_txn(40'h12345678AB, 128'h1, "clean");
        chk("clean_fault_count", bus.fault_count, 4'd0);

        // Fault marker on the ciphertext.
        enc_pulse(40'h000008C784, 128'h2);
        tick(2);
        dec_pulse(40'h77, 128'h88, 1'b1);
        wait_valid(10, l);
        chk("marker_out_fault", bus.out_fault, 1'b1);
        chk("marker_out_ct", bus.out_ct, 40'h0);
        chk("marker_out_tag", bus.out_tag, 128'h0);
        chk("marker_fault_count", bus.fault_count, 4'd1);
        tick(2);

        // Backpressure with an ignored encryption edge during HOLD.
        bus.out_ready = 1'b0;
        enc_pulse(40'hA5A5A5A5A5, 128'hDEADBEEF);
        tick();
        dec_pulse(40'h11, 128'h22, 1'b1);
        wait_valid(10, l);
        h0 = n_hs;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_out_ct", bus.out_ct, 40'hA5A5A5A5A5);
            bus.encryption_ready = (i == 1);
            tick();
        end
        bus.encryption_ready = 1'b0;
        bus.out_ready = 1'b1;
        tick(3);
        chk("bp_handshakes", n_hs - h0, 1);
        chk("bp_idle", bus.busy, 1'b0);

        // Lone decryption edge in IDLE.
        dec_pulse(40'h33, 128'h44, 1'b1);
        tick(3);
        chk("lone_dec_busy", bus.busy, 1'b0);
        chk("lone_dec_valid", bus.out_valid, 1'b0);

        // Simultaneous edges, authentication failed.
        bus.cipher_text = 40'h0F0F0F0F0F; bus.tag = 128'h3;
        bus.dec_plain_text = 40'h9; bus.dec_tag = 128'h4; bus.message_authentication = 1'b0;
        bus.encryption_ready = 1'b1; bus.decryption_ready = 1'b1;
        tick();
        bus.encryption_ready = 1'b0; bus.decryption_ready = 1'b0;
        chk("simul_check_busy", bus.busy, 1'b1);
        chk("simul_check_valid", bus.out_valid, 1'b0);
        tick();
        chk("simul_out_valid", bus.out_valid, 1'b1);
        chk("simul_out_fault", bus.out_fault, 1'b1);
        chk("simul_fault_count", bus.fault_count, 4'd2);
        tick(2);

        // Reset while waiting for decryption.
        enc_pulse(40'h42, 128'h43);
        tick(4);
        chk("wait_busy", bus.busy, 1'b1);
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_wait");
        rst = 1'b1;
        tick(2);

        // Three timeouts drive the block into lockout.
        for (int i = 0; i < 3; i++) begin
            enc_pulse(40'h1000 + 40'(i), 128'h5);
            wait_valid(1100, l);
            chk("tmo_latency", l, TIMEOUT + 2);
            chk("tmo_out_fault", bus.out_fault, 1'b1);
            tick();
        end
        chk("lock_locked", bus.locked, 1'b1);
        chk("lock_fault_count", bus.fault_count, 4'd3);
        v0 = n_vld_cyc;
        enc_pulse(40'h7, 128'h8);
        dec_pulse(40'h7, 128'h8, 1'b1);
        bus.encryption_ready = 1'b1; bus.decryption_ready = 1'b1;
        tick();
        bus.encryption_ready = 1'b0; bus.decryption_ready = 1'b0;
        tick(10);
        chk("lock_no_valid", n_vld_cyc - v0, 0);
        chk("lock_busy", bus.busy, 1'b1);

        // Reset out of lockout, then a normal transaction.
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_lock");
        rst = 1'b1;
        tick(2);
        clean_txn(40'hCAFEBABE01, 128'hF00D, "post_lock");

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
